// File: rtl/lab1_pkg.sv
// ============================================================================
// Module : lab1_pkg
// Brief  : Shared types and constants for the lab-function sweep block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lab1_pkg;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;

  // bit i = f({x1,x2,x3,x4} = i) for f = x1'x2'x3' + x1'x3'x4 + x1x2x4' + x2x3
  localparam logic [NUM_VEC-1:0] F_GOLDEN = 16'hD0E3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } sweep_state_t;

endpackage

`default_nettype wire

// File: rtl/lab_func_sweeper_if.sv
// ============================================================================
// Module : lab_func_sweeper_if
// Brief  : Controller and evaluator signal bundle for the lab-function sweeper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lab_func_sweeper_if;
  import lab1_pkg::*;

  logic               start;
  logic               abort;
  logic [VEC_W-1:0]   vec_out;
  logic               f_nand;
  logic               f_nor;
  logic               busy;
  logic               done;
  logic               pass;
  logic [NUM_VEC-1:0] truth_nand;
  logic [NUM_VEC-1:0] truth_nor;
  logic [4:0]         mismatch_cnt;
  logic               fail_valid;
  logic [VEC_W-1:0]   first_fail_idx;

  // master: the sweeper itself
  modport master (
    input  start, abort, f_nand, f_nor,
    output vec_out, busy, done, pass, truth_nand, truth_nor,
           mismatch_cnt, fail_valid, first_fail_idx
  );

  // slave: test controller plus evaluators
  modport slave (
    output start, abort, f_nand, f_nor,
    input  vec_out, busy, done, pass, truth_nand, truth_nor,
           mismatch_cnt, fail_valid, first_fail_idx
  );

endinterface

`default_nettype wire

// File: rtl/lab_func_sweeper.sv
// ============================================================================
// Module : lab_func_sweeper
// Brief  : Drives all 16 vectors to NAND/NOR evaluators, samples after a
//          settle delay and checks both truth tables against the golden one.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lab_func_sweeper
  import lab1_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 1,
  parameter logic [NUM_VEC-1:0] EXPECTED      = F_GOLDEN
) (
  input  logic               clk,
  input  logic               rst_n,
  lab_func_sweeper_if.master bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  sweep_state_t       state_q,      state_d;
  logic [VEC_W-1:0]   idx_q,        idx_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [NUM_VEC-1:0] truth_nand_q, truth_nand_d;
  logic [NUM_VEC-1:0] truth_nor_q,  truth_nor_d;
  logic [4:0]         mm_cnt_q,     mm_cnt_d;
  logic               fail_valid_q, fail_valid_d;
  logic [VEC_W-1:0]   ffi_q,        ffi_d;
  logic               pass_q,       pass_d;
  logic               vec_fail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      truth_nand_q <= '0;
      truth_nor_q  <= '0;
      mm_cnt_q     <= '0;
      fail_valid_q <= 1'b0;
      ffi_q        <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      truth_nand_q <= truth_nand_d;
      truth_nor_q  <= truth_nor_d;
      mm_cnt_q     <= mm_cnt_d;
      fail_valid_q <= fail_valid_d;
      ffi_q        <= ffi_d;
      pass_q       <= pass_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    truth_nand_d = truth_nand_q;
    truth_nor_d  = truth_nor_q;
    mm_cnt_d     = mm_cnt_q;
    fail_valid_d = fail_valid_q;
    ffi_d        = ffi_q;
    pass_d       = pass_q;
    vec_fail     = (bus.f_nand != EXPECTED[idx_q]) || (bus.f_nor != EXPECTED[idx_q]);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d      = ST_APPLY;
          idx_d        = '0;
          truth_nand_d = '0;
          truth_nor_d  = '0;
          mm_cnt_d     = '0;
          fail_valid_d = 1'b0;
          ffi_d        = '0;
          pass_d       = 1'b0;
        end
      end

      ST_APPLY: begin
        cnt_d = CNT_W'(SETTLE_CYCLES);
        if (bus.abort)
          state_d = ST_IDLE;
        else
          state_d = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
      end

      ST_SETTLE: begin
        if (bus.abort)
          state_d = ST_IDLE;
        else if (cnt_q <= CNT_W'(1))
          state_d = ST_SAMPLE;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end

      ST_SAMPLE: begin
        // an aborted sample is dropped entirely, tables stay as they were
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          truth_nand_d[idx_q] = bus.f_nand;
          truth_nor_d[idx_q]  = bus.f_nor;
          if (vec_fail) begin
            mm_cnt_d = mm_cnt_q + 5'd1;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              ffi_d        = idx_q;
            end
          end
          if (idx_q == VEC_W'(NUM_VEC - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + VEC_W'(1);
            state_d = ST_APPLY;
          end
        end
      end

      ST_DONE: begin
        pass_d  = (mm_cnt_q == 5'd0);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.done           = (state_q == ST_DONE);
  assign bus.vec_out        = (state_q == ST_APPLY || state_q == ST_SETTLE ||
                               state_q == ST_SAMPLE) ? idx_q : '0;
  assign bus.pass           = pass_q;
  assign bus.truth_nand     = truth_nand_q;
  assign bus.truth_nor      = truth_nor_q;
  assign bus.mismatch_cnt   = mm_cnt_q;
  assign bus.fail_valid     = fail_valid_q;
  assign bus.first_fail_idx = ffi_q;

endmodule

`default_nettype wire

// File: tb/tb_lab_func_sweeper.sv
// ============================================================================
// Module : tb_lab_func_sweeper
// Brief  : Self-checking bench for lab_func_sweeper at settle times 0, 1, 2.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lab_func_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lab_func_sweeper_if bus0 ();
  lab_func_sweeper_if bus1 ();
  lab_func_sweeper_if bus2 ();

  lab_func_sweeper #(.SETTLE_CYCLES(0)) u_s0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  lab_func_sweeper #(.SETTLE_CYCLES(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  lab_func_sweeper #(.SETTLE_CYCLES(2)) u_s2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // reference function straight from the boolean equation
  function automatic logic f_eq(input logic [3:0] v);
    logic x1, x2, x3, x4;
    {x1, x2, x3, x4} = v;
    return (!x1 && !x2 && !x3) || (!x1 && !x3 && x4) || (x1 && x2 && !x4) || (x2 && x3);
  endfunction

  // evaluator models with injectable faults
  logic [15:0] nand_flip = '0;
  logic [15:0] nor_flip  = '0;
  logic        nor_s0    = 1'b0;
  logic        start_v [3];
  logic        abort_v [3];

  assign bus0.f_nand = f_eq(bus0.vec_out) ^ nand_flip[bus0.vec_out];
  assign bus1.f_nand = f_eq(bus1.vec_out) ^ nand_flip[bus1.vec_out];
  assign bus2.f_nand = f_eq(bus2.vec_out) ^ nand_flip[bus2.vec_out];
  assign bus0.f_nor  = nor_s0 ? 1'b0 : (f_eq(bus0.vec_out) ^ nor_flip[bus0.vec_out]);
  assign bus1.f_nor  = nor_s0 ? 1'b0 : (f_eq(bus1.vec_out) ^ nor_flip[bus1.vec_out]);
  assign bus2.f_nor  = nor_s0 ? 1'b0 : (f_eq(bus2.vec_out) ^ nor_flip[bus2.vec_out]);
  assign bus0.start  = start_v[0];
  assign bus1.start  = start_v[1];
  assign bus2.start  = start_v[2];
  assign bus0.abort  = abort_v[0];
  assign bus1.abort  = abort_v[1];
  assign bus2.abort  = abort_v[2];

  typedef struct packed {
    logic [3:0]  vec;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] tn;
    logic [15:0] tr;
    logic [4:0]  cnt;
    logic        fv;
    logic [3:0]  ffi;
  } obs_t;

  obs_t obs [3];
  assign obs[0] = {bus0.vec_out, bus0.busy, bus0.done, bus0.pass, bus0.truth_nand,
                   bus0.truth_nor, bus0.mismatch_cnt, bus0.fail_valid, bus0.first_fail_idx};
  assign obs[1] = {bus1.vec_out, bus1.busy, bus1.done, bus1.pass, bus1.truth_nand,
                   bus1.truth_nor, bus1.mismatch_cnt, bus1.fail_valid, bus1.first_fail_idx};
  assign obs[2] = {bus2.vec_out, bus2.busy, bus2.done, bus2.pass, bus2.truth_nand,
                   bus2.truth_nor, bus2.mismatch_cnt, bus2.fail_valid, bus2.first_fail_idx};

  typedef struct {
    int          sel;         // instance index == its settle cycles
    int          restart_at;  // cycle of a stray start pulse, -1 for none
    logic [15:0] nand_flip;
    logic [15:0] nor_flip;
    logic        nor_s0;
    logic [15:0] exp_tn;
    logic [15:0] exp_tr;
    logic [4:0]  exp_cnt;
    logic        exp_fv;
    logic [3:0]  exp_ffi;
    logic        exp_pass;
  } vec_t;

  vec_t tbl [6];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start in the current cycle (cycle 0); scoreboard holds per-cycle
  // {vec_out, busy, done} derived from the sweep timing formulas.
  task automatic run_row(input int r, input vec_t t);
    logic [5:0] q[$];
    logic [5:0] e;
    int s;
    int dc;
    s  = t.sel;
    dc = 16 * (s + 2) + 1;
    nand_flip  = t.nand_flip;
    nor_flip   = t.nor_flip;
    nor_s0     = t.nor_s0;
    start_v[s] = 1'b1;
    for (int c = 1; c <= dc + 1; c++) begin
      if (c < dc) q.push_back({4'((c - 1) / (s + 2)), 1'b1, 1'b0});
      else if (c == dc) q.push_back({4'd0, 1'b1, 1'b1});
      else q.push_back(6'd0);
    end
    for (int c = 1; c <= dc + 1; c++) begin
      cyc();
      start_v[s] = (c == t.restart_at);
      e = q.pop_front();
      check($sformatf("r%0d_c%0d_vec_busy_done", r, c),
            {obs[s].vec, obs[s].busy, obs[s].done}, e);
    end
    check($sformatf("r%0d_truth_nand", r), obs[s].tn,   t.exp_tn);
    check($sformatf("r%0d_truth_nor", r),  obs[s].tr,   t.exp_tr);
    check($sformatf("r%0d_mm_cnt", r),     obs[s].cnt,  t.exp_cnt);
    check($sformatf("r%0d_fail_valid", r), obs[s].fv,   t.exp_fv);
    check($sformatf("r%0d_first_fail", r), obs[s].ffi,  t.exp_ffi);
    check($sformatf("r%0d_pass", r),       obs[s].pass, t.exp_pass);
    nand_flip = '0;
    nor_flip  = '0;
    nor_s0    = 1'b0;
  endtask

  initial begin
    logic [15:0] gold_eq;
    int done_seen;

    //            sel rst  nand_fl   nor_fl   s0  exp_tn    exp_tr    cnt fv ffi pass
    tbl[0] = '{1, -1, 16'h0000, 16'h0000, 0, 16'hD0E3, 16'hD0E3, 0, 0, 0,  1};
    tbl[1] = '{1, -1, 16'h0000, 16'h0000, 1, 16'hD0E3, 16'h0000, 8, 1, 0,  0};
    tbl[2] = '{1, -1, 16'h2000, 16'h0000, 0, 16'hF0E3, 16'hD0E3, 1, 1, 13, 0};
    tbl[3] = '{1, -1, 16'h0204, 16'h0200, 0, 16'hD2E7, 16'hD2E3, 2, 1, 2,  0};
    tbl[4] = '{0, 10, 16'h0000, 16'h0000, 0, 16'hD0E3, 16'hD0E3, 0, 0, 0,  1};
    tbl[5] = '{2, -1, 16'h0000, 16'h0000, 0, 16'hD0E3, 16'hD0E3, 0, 0, 0,  1};

    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) cyc();
    for (int i = 0; i < 3; i++) check($sformatf("reset_s%0d", i), obs[i], '0);
    rst_n = 1'b1;
    cyc();

    gold_eq = '0;
    for (int v = 0; v < 16; v++) gold_eq[v] = f_eq(4'(v));
    check("golden_equation", gold_eq, 16'hD0E3);

    for (int r = 0; r < 6; r++) run_row(r, tbl[r]);

    // abort on the SAMPLE of vector 4 (S=2); that vector's fault must not land
    nand_flip  = 16'h0010;
    nor_flip   = 16'h0010;
    start_v[2] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      start_v[2] = 1'b0;
    end
    check("abort_pre_vec_busy", {obs[2].vec, obs[2].busy}, {4'd4, 1'b1});
    abort_v[2] = 1'b1;
    cyc();
    abort_v[2] = 1'b0;
    check("abort_idle", {obs[2].vec, obs[2].busy, obs[2].done}, 6'd0);
    check("abort_truth_nand", obs[2].tn, 16'h0003);
    check("abort_truth_nor",  obs[2].tr, 16'h0003);
    check("abort_cnt_fv",     {obs[2].cnt, obs[2].fv}, 6'd0);
    check("abort_pass",       obs[2].pass, 1'b0);
    done_seen = 0;
    for (int c = 0; c < 70; c++) begin
      cyc();
      if (obs[2].done || obs[2].busy) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    nand_flip = '0;
    nor_flip  = '0;

    // start+abort together in IDLE, then abort in DONE (S=0)
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    cyc();
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    check("start_beats_abort", {obs[0].vec, obs[0].busy}, {4'd0, 1'b1});
    for (int c = 2; c <= 33; c++) cyc();
    check("s0_done_c33", obs[0].done, 1'b1);
    abort_v[0] = 1'b1;
    cyc();
    abort_v[0] = 1'b0;
    check("abort_in_done_ignored", {obs[0].pass, obs[0].busy}, {1'b1, 1'b0});

    // reset in the middle of an S=1 sweep, then a clean sweep
    start_v[1] = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      cyc();
      start_v[1] = 1'b0;
    end
    check("mid_sweep_partial", {obs[1].busy, obs[1].tn}, {1'b1, 16'h0003});
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("mid_sweep_reset", obs[1], '0);
    run_row(6, tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lab_func_sweeper.md
Name: lab_func_sweeper

Overview:
- Sequencer that exhaustively exercises the 4-input lab function f = x1'x2'x3' + x1'x3'x4 + x1x2x4' + x2x3 on silicon.
- Drives all 16 input vectors onto two gate-level evaluators of f, the NAND-only and the NOR-only implementations.
- Waits a programmable settle time per vector, then samples both outputs.
- Builds both truth tables and checks them against the golden table and against each other.
- Sits between a lab test controller (start/abort) and the two combinational evaluators; the integration wrapper lab1_sweep_top instantiates all three.

Parameters:
- SETTLE_CYCLES, 1, idle cycles between applying a vector and sampling (0 allowed).
- EXPECTED, 16'hD0E3, golden truth table; bit i = f({x1,x2,x3,x4} = i).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin sweep; honoured only in IDLE.
- abort  in  1  terminate sweep; ignored in IDLE.
- vec_out  out  4  {x1,x2,x3,x4} driven to both evaluators.
- f_nand  in  1  NAND-implementation output.
- f_nor  in  1  NOR-implementation output.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at completion of a full sweep.
- pass  out  1  no mismatches; valid from done, held until next start.
- truth_nand  out  16  sampled NAND table, bit i = vector i.
- truth_nor  out  16  sampled NOR table.
- mismatch_cnt  out  5  vectors failing (range 0..16).
- fail_valid  out  1  at least one failing vector seen this sweep.
- first_fail_idx  out  4  lowest failing vector index; valid when fail_valid.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - All outputs become 0, including vec_out, truth tables and counters.
  - Reset overrides start and abort in the same cycle.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE -> APPLY on start.
  - Same edge: idx <= 0; truth_nand, truth_nor, mismatch_cnt, fail_valid, first_fail_idx and pass are cleared.
- APPLY: vec_out = idx.
  - Settle counter loads SETTLE_CYCLES.
  - Next state is SETTLE, or SAMPLE if SETTLE_CYCLES = 0.
- SETTLE: counts down, holds for exactly SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE:
  - Records truth_nand[idx] <= f_nand and truth_nor[idx] <= f_nor.
  - The vector fails if f_nand != EXPECTED[idx] or f_nor != EXPECTED[idx]. A failing vector is counted once even if both evaluators are wrong.
  - On the first failure of the sweep: fail_valid <= 1 and first_fail_idx <= idx.
  - If idx = 15, next state is DONE. Otherwise idx <= idx+1 and next state is APPLY (no wrap-around).
- DONE:
  - done = 1 for this single cycle.
  - pass <= (mismatch_cnt final == 0).
  - Next state is IDLE.
- vec_out:
  - Holds idx, stable, through APPLY/SETTLE/SAMPLE.
  - Is 0 in IDLE and DONE.
- Timing, with start high in cycle 0 while IDLE:
  - Vector i is applied in cycle 1 + i(S+2).
  - Vector i is sampled in cycle (i+1)(S+2).
  - done is high in cycle 16(S+2)+1.
  - busy is high from cycle 1 through the done cycle inclusive.
- Abort in APPLY/SETTLE/SAMPLE:
  - Next state is IDLE.
  - done is not pulsed and pass stays 0.
  - Partial tables and counts are held.
  - Abort coinciding with a SAMPLE cycle: that sample is discarded.
- Abort in DONE: ignored, the sweep completes normally.
- start while busy: ignored.
- start and abort together in IDLE: start wins.
- mismatch_cnt saturation is not needed; 5 bits cover 16.

Decomposition:
- Shared package lab1_pkg holds:
  - state enum sweep_state_t;
  - constant F_GOLDEN = 16'hD0E3;
  - VEC_W = 4 and NUM_VEC = 16.
- No sub-module inside the sweeper.
- The settle down-counter is inline (width clog2(SETTLE_CYCLES+1), minimum 1).
- The evaluators stay separate and are wired by lab1_sweep_top.

Test Plan:
- Correct NAND and NOR evaluators, S=1, start pulse in cycle 0:
  - truth_nand = truth_nor = 16'hD0E3, mismatch_cnt=0, fail_valid=0;
  - done in cycle 49 only, then pass=1.
- f_nor forced stuck-at-0:
  - truth_nor=16'h0000, truth_nand=16'hD0E3;
  - mismatch_cnt=8, first_fail_idx=0, pass=0.
- f_nand inverted only when vec=13, f_nor correct:
  - truth_nand=16'hF0E3, mismatch_cnt=1, first_fail_idx=13, pass=0.
- S=0, correct evaluators:
  - vec_out steps 0..15 on odd cycles 1,3,…,31; done in cycle 33.
  - start re-pulsed in cycle 10 has no effect.
- S=2, abort in cycle 20:
  - IDLE in cycle 21, no done pulse, vec_out=0, pass=0.
  - Tables hold vectors 0–4, sampled in cycles 4,8,12,16,20; sample 4 discarded.
- rst_n low in cycle 15 of a sweep:
  - cycle 16 shows all outputs 0 and busy=0.
  - A new start then completes a normal sweep with pass=1.
